// File: rtl/tawas_dbus_arb_pkg.sv
// ----------------------------------------------------------------------------
// tawas_dbus_arb_pkg
// Shared definitions for the Tawas data-RAM port arbiter:
//   - FSM state encoding of the secondary holding register (IDLE / PEND)
//   - default starvation TIMEOUT (wait cycles, 8-bit counter)
//   - RAM read latency in cycles (registered read = 1)
//   - helper that rebuilds a word-aligned byte address from a word index
// ----------------------------------------------------------------------------
package tawas_dbus_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } arb_state_e;

    localparam int unsigned TIMEOUT_DEF = 32'd255;
    localparam int unsigned RD_LAT      = 32'd1;

    // Secondary addresses are byte addresses; the RAM only sees word-aligned ones.
    function automatic logic [31:0] word_addr(input logic [29:0] widx);
        return {widx, 2'b00};
    endfunction

endpackage

// File: rtl/tawas_dbus_wdog.sv
// ----------------------------------------------------------------------------
// tawas_dbus_wdog
// Starvation watchdog for the secondary requester. An 8-bit counter clears
// when a request is accepted and counts every cycle the held request is
// blocked by the core. When the count reaches TIMEOUT the sticky error flag
// sets and stays set until reset.
// Ports:
//   CLK  in  clock (rising edge)
//   RSTN in  synchronous active-low reset
//   clr  in  clear the wait counter (request accepted)
//   inc  in  one blocked wait cycle
//   err  out sticky starvation flag (registered)
// ----------------------------------------------------------------------------
module tawas_dbus_wdog
    import tawas_dbus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic clr,
    input  logic inc,
    output logic err
);

    localparam logic [7:0] TMO_C = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       err_q;
    logic       err_d;

    // Next counter / flag value; the counter saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (inc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
        if (inc && (cnt_d == TMO_C)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/tawas_dbus_arb.sv
// ----------------------------------------------------------------------------
// tawas_dbus_arb
// Data-RAM port arbiter between the Tawas load/store unit (core) and a
// secondary requester (DMA/debug). The core always wins and passes through
// with zero latency. One secondary request is held and issued in the first
// cycle the core leaves the RAM idle; completion is a one-cycle S_DONE pulse
// two cycles after issue, with read data in S_RDATA.
// Optional feature: define TAWAS_DBUS_TMO_EN to build the starvation
// watchdog (S_ERR); otherwise S_ERR is tied to 0.
// Ports:
//   CLK, RSTN                      clock, synchronous active-low reset
//   C_DADDR/C_DCS/C_DWR/C_DMASK/C_DOUT  core request, C_DIN read data
//   S_REQ/S_READY                  secondary valid/ready handshake
//   S_ADDR/S_WR/S_MASK/S_WDATA     secondary request fields
//   S_DONE/S_RDATA/S_ERR           secondary completion, data, starvation
//   DADDR/DCS/DWR/DMASK/DOUT, DIN  single-port RAM interface
// ----------------------------------------------------------------------------
module tawas_dbus_arb
    import tawas_dbus_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] C_DADDR,
    input  logic        C_DCS,
    input  logic        C_DWR,
    input  logic [3:0]  C_DMASK,
    input  logic [31:0] C_DOUT,
    output logic [31:0] C_DIN,
    input  logic        S_REQ,
    output logic        S_READY,
    input  logic [31:0] S_ADDR,
    input  logic        S_WR,
    input  logic [3:0]  S_MASK,
    input  logic [31:0] S_WDATA,
    output logic        S_DONE,
    output logic [31:0] S_RDATA,
    output logic        S_ERR,
    output logic [31:0] DADDR,
    output logic        DCS,
    output logic        DWR,
    output logic [3:0]  DMASK,
    output logic [31:0] DOUT,
    input  logic [31:0] DIN
);

    arb_state_e          state_q;
    arb_state_e          state_d;
    logic [29:0]         hold_addr_q;
    logic [29:0]         hold_addr_d;
    logic                hold_wr_q;
    logic                hold_wr_d;
    logic [3:0]          hold_mask_q;
    logic [3:0]          hold_mask_d;
    logic [31:0]         hold_wdata_q;
    logic [31:0]         hold_wdata_d;
    logic [RD_LAT-1:0]   iss_q;
    logic [RD_LAT-1:0]   iss_d;
    logic [RD_LAT-1:0]   rd_q;
    logic [RD_LAT-1:0]   rd_d;
    logic                done_q;
    logic                done_d;
    logic [31:0]         rdata_q;
    logic [31:0]         rdata_d;
    logic                accept_s;
    logic                grant_s;
    logic                addr_unused_s;

    // Grant is suppressed while reset is held so a pending request never
    // reaches the RAM during reset.
    assign accept_s = S_REQ && (state_q == ST_IDLE);
    assign grant_s  = (state_q == ST_PEND) && !C_DCS && RSTN;

    // Byte offset of the secondary address is dropped on purpose.
    assign addr_unused_s = ^S_ADDR[1:0];

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            hold_addr_q  <= 30'd0;
            hold_wr_q    <= 1'b0;
            hold_mask_q  <= 4'd0;
            hold_wdata_q <= 32'd0;
            iss_q        <= '0;
            rd_q         <= '0;
            done_q       <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_wr_q    <= hold_wr_d;
            hold_mask_q  <= hold_mask_d;
            hold_wdata_q <= hold_wdata_d;
            iss_q        <= iss_d;
            rd_q         <= rd_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state logic of the holding-register FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_PEND;
                else          state_d = ST_IDLE;
            end
            ST_PEND: begin
                if (grant_s) state_d = ST_IDLE;
                else         state_d = ST_PEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM port mux: core has absolute priority, then the held request, else idle zeros.
    always_comb begin
        DADDR = 32'd0;
        DCS   = 1'b0;
        DWR   = 1'b0;
        DMASK = 4'd0;
        DOUT  = 32'd0;
        if (C_DCS) begin
            DADDR = C_DADDR;
            DCS   = 1'b1;
            DWR   = C_DWR;
            DMASK = C_DMASK;
            DOUT  = C_DOUT;
        end else if (grant_s) begin
            DADDR = word_addr(hold_addr_q);
            DCS   = 1'b1;
            DWR   = hold_wr_q;
            DMASK = hold_mask_q;
            DOUT  = hold_wdata_q;
        end else begin
            DADDR = 32'd0;
            DCS   = 1'b0;
            DWR   = 1'b0;
            DMASK = 4'd0;
            DOUT  = 32'd0;
        end
    end

    // Holding register capture and completion pipeline. The issue/read
    // shift registers are RD_LAT deep so data is captured the cycle the RAM
    // presents it, and S_DONE follows one cycle later.
    always_comb begin
        hold_addr_d  = hold_addr_q;
        hold_wr_d    = hold_wr_q;
        hold_mask_d  = hold_mask_q;
        hold_wdata_d = hold_wdata_q;
        if (accept_s) begin
            hold_addr_d  = S_ADDR[31:2];
            hold_wr_d    = S_WR;
            hold_mask_d  = S_MASK;
            hold_wdata_d = S_WDATA;
        end else begin
            hold_addr_d  = hold_addr_q;
            hold_wr_d    = hold_wr_q;
            hold_mask_d  = hold_mask_q;
            hold_wdata_d = hold_wdata_q;
        end
        iss_d  = (iss_q << 1'b1) | RD_LAT'(grant_s);
        rd_d   = (rd_q << 1'b1) | RD_LAT'(grant_s && !hold_wr_q);
        done_d = iss_q[RD_LAT-1];
        if (rd_q[RD_LAT-1]) rdata_d = DIN;
        else                rdata_d = rdata_q;
    end

    assign S_READY = (state_q == ST_IDLE);
    assign S_DONE  = done_q;
    assign S_RDATA = rdata_q;
    assign C_DIN   = DIN;

`ifdef TAWAS_DBUS_TMO_EN
    logic wdog_inc_s;
    logic wdog_err_s;

    assign wdog_inc_s = (state_q == ST_PEND) && C_DCS;

    tawas_dbus_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .CLK  (CLK),
        .RSTN (RSTN),
        .clr  (accept_s),
        .inc  (wdog_inc_s),
        .err  (wdog_err_s)
    );

    assign S_ERR = wdog_err_s;
`else
    // The timeout value has no consumer when the watchdog is not built.
    logic tmo_unused_s;
    assign tmo_unused_s = ^(8'(TIMEOUT));
    assign S_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_tawas_dbus_arb.sv
// ----------------------------------------------------------------------------
// tb_tawas_dbus_arb
// Self-checking bench: a stimulus process drives core and secondary traffic
// and, from the arbitration rules, predicts grants, completions and read
// data into a scoreboard; a monitor on the falling edge checks the RAM port,
// handshake and completions against those predictions.
// ----------------------------------------------------------------------------
module tb_tawas_dbus_arb;

    localparam int unsigned TMO = 3;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] C_DADDR = 32'd0;
    logic        C_DCS = 1'b0;
    logic        C_DWR = 1'b0;
    logic [3:0]  C_DMASK = 4'd0;
    logic [31:0] C_DOUT = 32'd0;
    logic [31:0] C_DIN;
    logic        S_REQ = 1'b0;
    logic        S_READY;
    logic [31:0] S_ADDR = 32'd0;
    logic        S_WR = 1'b0;
    logic [3:0]  S_MASK = 4'd0;
    logic [31:0] S_WDATA = 32'd0;
    logic        S_DONE;
    logic [31:0] S_RDATA;
    logic        S_ERR;
    logic [31:0] DADDR;
    logic        DCS;
    logic        DWR;
    logic [3:0]  DMASK;
    logic [31:0] DOUT;
    logic [31:0] DIN = 32'd0;

    tawas_dbus_arb #(.TIMEOUT(TMO)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .C_DADDR(C_DADDR), .C_DCS(C_DCS), .C_DWR(C_DWR), .C_DMASK(C_DMASK),
        .C_DOUT(C_DOUT), .C_DIN(C_DIN),
        .S_REQ(S_REQ), .S_READY(S_READY), .S_ADDR(S_ADDR), .S_WR(S_WR),
        .S_MASK(S_MASK), .S_WDATA(S_WDATA), .S_DONE(S_DONE), .S_RDATA(S_RDATA),
        .S_ERR(S_ERR),
        .DADDR(DADDR), .DCS(DCS), .DWR(DWR), .DMASK(DMASK), .DOUT(DOUT), .DIN(DIN)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct { int unsigned cyc; logic rd; logic [31:0] data; } done_t;
    typedef struct { logic [31:0] addr; logic wr; logic [3:0] mask; logic [31:0] wdata; logic [31:0] rdata; } txn_t;

    done_t       done_q[$];
    logic [31:0] ram_mem [0:1023];
    logic [31:0] ref_mem [0:255];

    logic exp_ready = 1'b1;
    logic exp_grant = 1'b0;
    logic exp_err   = 1'b0;
    txn_t held;
    logic m_pend = 1'b0;
    int   m_wait = 0;
    logic m_err  = 1'b0;

    function automatic logic [31:0] init_word(input int idx);
        return 32'hC3A5_0F00 ^ (32'(idx) * 32'h0101_0041);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Core region lives at 0x1000+, secondary region below 0x400: no aliasing.
    function automatic logic [9:0] ram_idx(input logic [31:0] a);
        return {a[12], a[10:2]};
    endfunction

    initial begin
        for (int j = 0; j < 1024; j++) ram_mem[j] = init_word(j);
        for (int j = 0; j < 256; j++) ref_mem[j] = init_word(j);
        ram_mem[10'h080] = 32'hDEADBEEF;
        ref_mem[8'h80]   = 32'hDEADBEEF;
    end

    // Single-port RAM with one-cycle registered read.
    always @(posedge CLK) begin
        if (DCS) begin
            if (DWR) ram_mem[ram_idx(DADDR)] <= merge(ram_mem[ram_idx(DADDR)], DOUT, DMASK);
            else     DIN <= ram_mem[ram_idx(DADDR)];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle and predict what the arbiter must do in it.
    task automatic drive(input logic rstn, input logic cdcs, input logic [31:0] caddr,
                         input logic cwr, input logic [3:0] cmask, input logic [31:0] cdout,
                         input logic sreq, input logic [31:0] saddr, input logic swr,
                         input logic [3:0] smask, input logic [31:0] swdata);
        logic [7:0] idx;
        @(posedge CLK);
        #1;
        RSTN = rstn; C_DCS = cdcs; C_DADDR = caddr; C_DWR = cwr; C_DMASK = cmask; C_DOUT = cdout;
        S_REQ = sreq; S_ADDR = saddr; S_WR = swr; S_MASK = smask; S_WDATA = swdata;
        exp_ready = !m_pend;
        exp_err   = m_err;
        exp_grant = m_pend && !cdcs && rstn;
        if (!rstn) begin
            m_pend = 1'b0;
            m_wait = 0;
            m_err  = 1'b0;
        end else if (exp_grant) begin
            done_q.push_back('{cyc + 2, !held.wr, held.rdata});
            m_pend = 1'b0;
        end else if (m_pend) begin
`ifdef TAWAS_DBUS_TMO_EN
            m_wait++;
            if (m_wait == int'(TMO)) m_err = 1'b1;
`endif
        end else if (sreq) begin
            held.addr  = {saddr[31:2], 2'b00};
            held.wr    = swr;
            held.mask  = smask;
            held.wdata = swdata;
            held.rdata = 32'd0;
            idx = saddr[9:2];
            if (swr) ref_mem[idx] = merge(ref_mem[idx], swdata, smask);
            else     held.rdata = ref_mem[idx];
            m_pend = 1'b1;
            m_wait = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    task automatic core_busy(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b1, 1'b1, 32'h0000_1000 + 32'(k * 4), 1'b0, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    // Monitor: checks every cycle against the predictions.
    initial begin : monitor
        logic [31:0] m_rdata;
        logic        exp_done;
        done_t       d;
        m_rdata = 32'd0;
        forever begin
            @(negedge CLK);
            if (!RSTN) begin
                if (!C_DCS) chk("rst_no_drive", {31'd0, DCS}, 32'd0);
                done_q.delete();
                m_rdata = 32'd0;
            end else begin
                chk("c_din", C_DIN, DIN);
                if (C_DCS) begin
                    chk("core_dcs", {31'd0, DCS}, 32'd1);
                    chk("core_daddr", DADDR, C_DADDR);
                    chk("core_ctl", {27'd0, DWR, DMASK}, {27'd0, C_DWR, C_DMASK});
                    chk("core_dout", DOUT, C_DOUT);
                end else if (exp_grant) begin
                    chk("sec_dcs", {31'd0, DCS}, 32'd1);
                    chk("sec_daddr", DADDR, held.addr);
                    chk("sec_ctl", {27'd0, DWR, DMASK}, {27'd0, held.wr, held.mask});
                    chk("sec_dout", DOUT, held.wdata);
                end else begin
                    chk("idle_port", {27'd0, DCS, DWR, DMASK} | DADDR | DOUT, 32'd0);
                end
                chk("s_ready", {31'd0, S_READY}, {31'd0, exp_ready});
                chk("s_err", {31'd0, S_ERR}, {31'd0, exp_err});
                exp_done = (done_q.size() > 0) && (done_q[0].cyc == cyc);
                chk("s_done", {31'd0, S_DONE}, {31'd0, exp_done});
                if (exp_done) begin
                    d = done_q.pop_front();
                    if (d.rd) m_rdata = d.data;
                end
                chk("s_rdata", S_RDATA, m_rdata);
            end
        end
    end

    initial begin : stimulus
        int guard;
        // Reset, then core-only read of 0x100.
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle(2);
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle(1);
        // Secondary read of 0x203 with the core idle.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_0203, 1'b0, 4'hF, 32'd0);
        idle(4);
        // Write accepted while the core is busy, core busy 4 more cycles.
        drive(1'b1, 1'b1, 32'h0000_1010, 1'b1, 4'hF, 32'hAAAA_5555, 1'b1, 32'h0000_00C6, 1'b1, 4'b0011, 32'h1234_5678);
        core_busy(4);
        idle(3);
        // Read it back, then back-to-back reads with the core idle.
        drive(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_00C4, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 6; k++)
            drive(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_0040 + 32'(k * 4), 1'b0, 4'd0, 32'd0);
        idle(4);
        // Long core stretch with a request pending (starvation).
        drive(1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'h0000_0300, 1'b0, 4'd0, 32'd0);
        core_busy(5);
        idle(6);
        // Reset while a request is pending: nothing may be issued or completed.
        drive(1'b1, 1'b1, 32'h0000_1020, 1'b0, 4'hF, 32'd0, 1'b1, 32'h0000_0080, 1'b0, 4'd0, 32'd0);
        core_busy(1);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0);
        idle(4);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(1'b1, 1'($urandom_range(0, 99) < 45),
                  32'h0000_1000 | 32'($urandom_range(0, 255) << 2),
                  1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                  1'($urandom_range(0, 99) < 60), 32'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 1)), 4'($urandom), $urandom);
        end
        guard = 0;
        while ((done_q.size() != 0) && (guard < 20)) begin
            idle(1);
            guard++;
        end
        idle(2);
        @(negedge CLK);
        #1;
        chk("drain", 32'(done_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
